// File: rtl/seq_detect_frame_ctrl.sv
// seq_detect_frame_ctrl
//   Feeds framed parallel words, MSB first, into an external serial "1011"
//   detector and counts the detector hits in each frame. A one-word skid
//   buffer lets the next word of a frame arrive while the current word is
//   still being shifted, so back-to-back words form one continuous bit stream.
//   The detector is held in reset between frames.
//
//   Handshake: a word transfers on a rising clock edge where in_valid and
//   in_ready are both 1. in_ready depends only on internal state, never on
//   in_valid. A requester that sees in_ready=0 keeps in_data/in_last stable.
//
// Ports
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   in_data          word to scan, bit WORD_W-1 shifted out first
//   in_valid/in_last word valid / word is the final word of its frame
//   in_ready         controller takes a word this cycle
//   det_seq_in       serial bit to the detector
//   det_reset        registered active-high reset to the detector
//   det_out          detector hit (combinational in the detector)
//   busy             frame in progress (SHIFT state)
//   done             one-cycle pulse at end of frame (normal or underrun)
//   err              underrun flag, held until the next frame is taken
//   match_count      saturating hit count of current/last frame
module seq_detect_frame_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              det_seq_in,
    output logic              det_reset,
    input  logic              det_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  match_count
);

    localparam int BC_W = $clog2(WORD_W);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                cur_last_q, cur_last_d;     // word in shifter is last
    logic [WORD_W-1:0]   skid_q, skid_d;
    logic                skid_last_q, skid_last_d;
    logic                skid_full_q, skid_full_d;
    logic                frame_last_q, frame_last_d; // last word of frame already taken
    logic [CNT_W-1:0]    match_q, match_d;
    logic                err_q, err_d;
    logic                det_reset_q, det_reset_d;

    logic accept;
    logic at_boundary;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        cur_last_d   = cur_last_q;
        skid_d       = skid_q;
        skid_last_d  = skid_last_q;
        skid_full_d  = skid_full_q;
        frame_last_d = frame_last_q;
        match_d      = match_q;
        err_d        = err_q;
        in_ready     = 1'b0;

        case (state_q)
            ST_IDLE:  in_ready = 1'b1;
            ST_SHIFT: in_ready = !skid_full_q && !frame_last_q;
            default:  in_ready = 1'b0;
        endcase

        accept      = in_valid && in_ready;
        at_boundary = (bit_cnt_q == LAST_BIT);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d      = in_data;
                    cur_last_d   = in_last;
                    frame_last_d = in_last;
                    skid_full_d  = 1'b0;
                    bit_cnt_d    = '0;
                    match_d      = '0;
                    err_d        = 1'b0;
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (det_out && (match_q != CNT_MAX)) begin
                    match_d = match_q + 1'b1;
                end
                if (accept) begin
                    frame_last_d = frame_last_q | in_last;
                end
                // A word taken mid-word parks in the skid buffer; a word
                // taken at the boundary can only mean the buffer is empty,
                // so it goes straight into the shifter below.
                if (accept && !at_boundary) begin
                    skid_d      = in_data;
                    skid_last_d = in_last;
                    skid_full_d = 1'b1;
                end
                if (!at_boundary) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (cur_last_q) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DONE;
                end else if (skid_full_q) begin
                    shift_d     = skid_q;
                    cur_last_d  = skid_last_q;
                    skid_full_d = 1'b0;
                    bit_cnt_d   = '0;
                end else if (accept) begin
                    shift_d    = in_data;
                    cur_last_d = in_last;
                    bit_cnt_d  = '0;
                end else begin
                    // Next word did not arrive in time: the stream would break.
                    err_d     = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so the detector leaves reset exactly on the edge that
        // enters SHIFT and re-enters reset on the edge that leaves it.
        det_reset_d = (state_d != ST_SHIFT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            cur_last_q   <= 1'b0;
            skid_q       <= '0;
            skid_last_q  <= 1'b0;
            skid_full_q  <= 1'b0;
            frame_last_q <= 1'b0;
            match_q      <= '0;
            err_q        <= 1'b0;
            det_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            cur_last_q   <= cur_last_d;
            skid_q       <= skid_d;
            skid_last_q  <= skid_last_d;
            skid_full_q  <= skid_full_d;
            frame_last_q <= frame_last_d;
            match_q      <= match_d;
            err_q        <= err_d;
            det_reset_q  <= det_reset_d;
        end
    end

    assign det_seq_in  = (state_q == ST_SHIFT) && shift_q[WORD_W-1];
    assign det_reset   = det_reset_q;
    assign busy        = (state_q == ST_SHIFT);
    assign done        = (state_q == ST_DONE);
    assign err         = err_q;
    assign match_count = match_q;

endmodule

// File: tb/tb_seq_detect_frame_ctrl.sv
// Bench for seq_detect_frame_ctrl. Two instances share the input stream: one
// with an 8-bit counter and one with a 2-bit counter to exercise saturation.
// Each instance drives its own behavioural "1011" detector. Expected values
// come from a frame-level model: word arrival times, the continuous bit
// string of the frame and an overlapping substring count over it.
module tb_seq_detect_frame_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;

    logic       in_ready8, det_seq_in8, det_reset8, det_out8, busy8, done8, err8;
    logic [7:0] match8;
    logic       in_ready2, det_seq_in2, det_reset2, det_out2, busy2, done2, err2;
    logic [1:0] match2;

    int checks;
    int failures;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_detect_frame_ctrl #(.WORD_W(8), .CNT_W(8)) dut8 (
        .clock(clk), .reset_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready8), .det_seq_in(det_seq_in8),
        .det_reset(det_reset8), .det_out(det_out8), .busy(busy8), .done(done8),
        .err(err8), .match_count(match8)
    );

    seq_detect_frame_ctrl #(.WORD_W(8), .CNT_W(2)) dut2 (
        .clock(clk), .reset_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready2), .det_seq_in(det_seq_in2),
        .det_reset(det_reset2), .det_out(det_out2), .busy(busy2), .done(done2),
        .err(err2), .match_count(match2)
    );

    // ---------------- detector models (last 3 bits + fill count) ----------------
    logic [2:0] hist8, hist2;
    logic [1:0] nb8, nb2;

    always @(posedge clk) begin
        if (det_reset8) begin
            hist8 <= 3'b000;
            nb8   <= 2'd0;
        end else begin
            hist8 <= {hist8[1:0], det_seq_in8};
            if (nb8 != 2'd3) nb8 <= nb8 + 2'd1;
        end
    end

    always @(posedge clk) begin
        if (det_reset2) begin
            hist2 <= 3'b000;
            nb2   <= 2'd0;
        end else begin
            hist2 <= {hist2[1:0], det_seq_in2};
            if (nb2 != 2'd3) nb2 <= nb2 + 2'd1;
        end
    end

    assign det_out8 = (nb8 == 2'd3) && (hist8 == 3'b101) && det_seq_in8;
    assign det_out2 = (nb2 == 2'd3) && (hist2 == 3'b101) && det_seq_in2;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // ---------------- frame description and held results ----------------
    logic [7:0] fr_w[8];
    int         fr_g[8];   // cycles after previous accept before word k is offered
    int         fr_n;
    bit         fr_last;

    int last_cnt8;
    int last_cnt2;
    bit last_err;

    // Idle cycles: controller waits in IDLE with results held.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = 8'($urandom);
            check_eq("idle_done", done8, 0);
            check_eq("idle_busy", busy8, 0);
            check_eq("idle_ready", in_ready8, 1);
            check_eq("idle_det_reset", det_reset8, 1);
            check_eq("idle_seq_in", det_seq_in8, 0);
            check_eq("idle_count8", match8, last_cnt8);
            check_eq("idle_count2", match2, last_cnt2);
            check_eq("idle_err", err8, last_err);
        end
    endtask

    // Run one frame starting at the current negedge (controller in IDLE).
    // Cycle 0 is the acceptance cycle of word 0; the bits of word k occupy
    // cycles 8k+1 .. 8k+8. Word k (k>=1) is taken once offered and once the
    // previous word has started shifting; it must arrive by cycle 8k.
    task automatic run_frame();
        int   acc[8];
        int   shifted;
        bit   under;
        int   done_cyc;
        logic bits[64];
        int   cum[65];
        int   nk;
        int   pres;
        int   ak;
        int   e8;
        int   e2;

        acc[0]  = 0;
        shifted = 1;
        under   = 1'b0;
        for (int k = 1; k < fr_n; k++) begin
            pres = acc[k-1] + fr_g[k];
            ak   = (pres > 8*(k-1)+1) ? pres : 8*(k-1)+1;
            if (ak > 8*k) begin
                under = 1'b1;
                break;
            end
            acc[k]  = ak;
            shifted = k + 1;
        end
        if (!under && !fr_last) under = 1'b1;
        done_cyc = 8*shifted + 1;

        for (int k = 0; k < shifted; k++)
            for (int b = 0; b < 8; b++)
                bits[8*k + b] = fr_w[k][7-b];
        cum[0] = 0;
        for (int i = 0; i < 8*shifted; i++)
            cum[i+1] = cum[i] + ((i >= 3 && bits[i-3] && !bits[i-2] && bits[i-1] && bits[i]) ? 1 : 0);

        in_valid = 1'b1;
        in_data  = fr_w[0];
        in_last  = fr_last && (fr_n == 1);
        check_eq("start_ready", in_ready8, 1);
        check_eq("start_count8", match8, last_cnt8);

        nk = 1;
        for (int c = 1; c <= done_cyc; c++) begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = 8'($urandom);
            if (nk < shifted && c >= acc[nk-1] + fr_g[nk]) begin
                in_valid = 1'b1;
                in_data  = fr_w[nk];
                in_last  = fr_last && (nk == fr_n - 1);
                check_eq("word_ready", in_ready8, (c == acc[nk]) ? 1 : 0);
                if (c == acc[nk]) nk++;
            end
            e8 = (cum[c-1] > 255) ? 255 : cum[c-1];
            e2 = (cum[c-1] > 3) ? 3 : cum[c-1];
            check_eq("done", done8, (c == done_cyc) ? 1 : 0);
            check_eq("done2", done2, (c == done_cyc) ? 1 : 0);
            check_eq("busy", busy8, (c < done_cyc) ? 1 : 0);
            check_eq("det_reset", det_reset8, (c == done_cyc) ? 1 : 0);
            check_eq("seq_in", det_seq_in8, (c < done_cyc) ? 32'(bits[c-1]) : 0);
            check_eq("count8", match8, e8);
            check_eq("count2", match2, e2);
            if (c == 1) check_eq("err_cleared", err8, 0);
            if (c == done_cyc) check_eq("err_end", err8, under);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        last_cnt8 = (cum[8*shifted] > 255) ? 255 : cum[8*shifted];
        last_cnt2 = (cum[8*shifted] > 3) ? 3 : cum[8*shifted];
        last_err  = under;
    endtask

    task automatic set_frame(input int n, input bit last, input logic [7:0] w0,
                             input logic [7:0] w1, input int g1);
        fr_n    = n;
        fr_last = last;
        fr_w[0] = w0;
        fr_w[1] = w1;
        fr_g[1] = g1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks    = 0;
        failures  = 0;
        last_cnt8 = 0;
        last_cnt2 = 0;
        last_err  = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;

        repeat (3) @(negedge clk);
        check_eq("rst_det_reset", det_reset8, 1);
        check_eq("rst_seq_in", det_seq_in8, 0);
        check_eq("rst_busy", busy8, 0);
        check_eq("rst_done", done8, 0);
        check_eq("rst_err", err8, 0);
        check_eq("rst_count", match8, 0);
        check_eq("rst_ready", in_ready8, 1);
        rst_n = 1'b1;
        idle_cycles(2);

        // Directed frames.
        set_frame(1, 1'b1, 8'b1011_0000, 8'h00, 1);  run_frame(); idle_cycles(1);
        check_eq("t1_count", last_cnt8, 1);
        set_frame(1, 1'b1, 8'b1011_0110, 8'h00, 1);  run_frame(); idle_cycles(2);
        check_eq("t2_count", last_cnt8, 2);
        set_frame(2, 1'b1, 8'b0000_0101, 8'b1000_0000, 1); run_frame(); idle_cycles(1);
        check_eq("t3_count", last_cnt8, 1);
        set_frame(1, 1'b0, 8'b1011_1011, 8'h00, 1);  run_frame(); idle_cycles(1);
        check_eq("t4_count", last_cnt8, 2);
        set_frame(2, 1'b1, 8'b1011_1011, 8'b1011_1011, 1); run_frame(); idle_cycles(1);
        check_eq("t5_count2", last_cnt2, 3);
        check_eq("t5_count8", last_cnt8, 4);
        set_frame(2, 1'b1, 8'hA5, 8'h3C, 10); run_frame(); idle_cycles(1);

        // Reset in the middle of a frame, during bit 4.
        in_valid = 1'b1;
        in_data  = 8'b1011_1011;
        in_last  = 1'b1;
        check_eq("mid_start_ready", in_ready8, 1);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        check_eq("mid_count_before", match8, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_det_reset", det_reset8, 1);
        check_eq("mid_busy", busy8, 0);
        check_eq("mid_count", match8, 0);
        check_eq("mid_done", done8, 0);
        check_eq("mid_seq_in", det_seq_in8, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("mid_no_done", done8, 0);
        end
        rst_n     = 1'b1;
        last_cnt8 = 0;
        last_cnt2 = 0;
        last_err  = 1'b0;
        idle_cycles(1);
        set_frame(1, 1'b1, 8'b1011_0110, 8'h00, 1); run_frame(); idle_cycles(1);

        // Randomized frames: random words, offer gaps (some cause underrun),
        // random last flag and idle spacing.
        for (int f = 0; f < 60; f++) begin
            fr_n    = $urandom_range(1, 4);
            fr_last = ($urandom_range(0, 5) != 0);
            for (int k = 0; k < fr_n; k++) begin
                fr_w[k] = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'hBB ^ 8'($urandom_range(0, 7));
                fr_g[k] = $urandom_range(1, 11);
            end
            run_frame();
            idle_cycles($urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
